// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and a
// 2-of-3 vote helper used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK_WAIT
   } rx_state_t;

   localparam int unsigned UART_DATA_BITS            = 9;
   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 217;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
// Both stages reset to 1 so a held reset never looks like a start bit.
module uart_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic sync
);

   logic meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
      end else begin
         meta <= pin;
         sync <= meta;
      end
   end

endmodule

// File: rtl/uart_frame_receiver.sv
// Asynchronous frame receiver: start bit, DATA_BITS data bits LSB-first, stop bit.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point.
module uart_frame_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 framing_error
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   rx_state_t            state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [IW-1:0]        idx, idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 done_n;
   logic                 fe_n;
   logic                 rx_s;
   logic                 tick;
   logic                 decide;
   logic                 bit_val;

   uart_sync2 u_sync (
      .clock (clock),
      .reset (reset),
      .pin   (rx),
      .sync  (rx_s)
   );

   always_comb begin
      tick = 1'b0;
      case (state)
         START:     tick = (cnt == HALF_LAST);
         DATA,
         STOP:      tick = (cnt == BIT_LAST);
         default:   tick = 1'b0;
      endcase
   end

`ifdef UART_RX_MAJORITY_EN
   // The counter keeps running through the extra cycle, so the next
   // midpoint is unaffected; only the decision lags the mid tick by one.
   logic       pend;
   logic [1:0] hist;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend <= 1'b0;
         hist <= '1;
      end else begin
         pend <= tick;
         hist <= {hist[0], rx_s};
      end
   end

   assign decide  = pend;
   assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
   assign decide  = tick;
   assign bit_val = rx_s;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data;
      done_n  = 1'b0;
      fe_n    = framing_error;

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end

         START: begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (decide) begin
               if (bit_val) begin
                  state_n = IDLE;
               end else begin
                  idx_n   = '0;
                  state_n = DATA;
               end
            end
         end

         DATA: begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (decide) begin
               shreg_n[idx] = bit_val;
               idx_n        = idx + 1'b1;
               if (idx == IDX_LAST) state_n = STOP;
            end
         end

         STOP: begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (decide) begin
               if (bit_val) begin
                  data_n  = shreg;
                  done_n  = 1'b1;
                  fe_n    = 1'b0;
                  state_n = IDLE;
               end else begin
                  fe_n    = 1'b1;
                  state_n = BREAK_WAIT;
               end
            end
         end

         BREAK_WAIT: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end

         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         data          <= '0;
         done          <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         idx           <= idx_n;
         shreg         <= shreg_n;
         data          <= data_n;
         done          <= done_n;
         framing_error <= fe_n;
      end
   end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Serial receive front end for the ATC controller; sits directly upstream of the request FIFO that takes 9-bit words and a write strobe.
- Recovers 11-bit asynchronous frames from the rx pin: 1 start bit (low), 9 data bits LSB-first, 1 stop bit (high).
- Emits each good frame as a 9-bit word with a 1-cycle done pulse, and flags stop-bit violations on framing_error, which drives a status pin.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit period (25 MHz / 115200); legal range >= 8.
- DATA_BITS, 9, data bits per frame; fixed at 9 for the request format, parameterised for reuse.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; reset is asserted while low.
- rx  input  1  raw serial line, asynchronous to clock; idles high.
- data  output  DATA_BITS  last correctly framed word; holds its value between frames.
- done  output  1  single-cycle pulse; data is valid in the same cycle.
- framing_error  output  1  level; set on a bad stop bit, cleared by the next good frame.

Behaviour:
- Reset values (while reset is low): data=0, done=0, framing_error=0, state=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame immediately. After release the block waits in IDLE for a fresh falling edge.
- rx passes through a 2-flop synchronizer. rx_s denotes the second flop output. All decisions use rx_s only.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index: width $clog2(DATA_BITS+1).
- IDLE:
  - On rx_s==0, clear the bit counter and go to START.
  - done=0.
- START:
  - Count to CLKS_PER_BIT/2 (floor) to reach the sample point.
  - If the sample is 0, clear the counter, set bit index to 0, go to DATA.
  - If the sample is 1, treat it as a false start: go to IDLE with no done and no error.
- DATA:
  - Every CLKS_PER_BIT cycles, sample the line into shift position bit index (LSB first) and increment the index.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample the stop bit.
  - Sample 1: load data from the shift register, pulse done for exactly 1 cycle, clear framing_error, go to IDLE.
  - Sample 0: set framing_error=1, leave data unchanged, no done, go to BREAK_WAIT.
- BREAK_WAIT:
  - Stay while rx_s==0. Go to IDLE on the first rx_s==1.
  - This prevents a held-low break line from being decoded as a stream of frames.
- Timing: let t0 be the first cycle with rx_s==0 in IDLE.
  - Start sample: t0 + CLKS_PER_BIT/2.
  - Data bit k sample (k = 0..8): start sample + (k+1)*CLKS_PER_BIT.
  - Stop sample: start sample + 10*CLKS_PER_BIT.
  - done: high in the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered one cycle after the stop sample. A start bit that begins immediately after the stop bit's nominal end is accepted.
- done never asserts on a false start, on a framing error, or during reset.
- The downstream FIFO must accept every done pulse. There is no backpressure; overflow policy belongs to the consumer.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start, data and stop) takes three samples of rx_s, at mid-1, mid and mid+1.
  - The bit value is the 2-of-3 majority.
  - Transitions that depend on the sample occur one cycle later than without the macro, so done occurs one cycle later.
- Undefined: single sample at mid; the timing listed above applies exactly.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK_WAIT.
  - Constants UART_DATA_BITS=9 and UART_CLKS_PER_BIT_DEFAULT=217, also used by the transmitter.
- One sub-module, uart_sync2: 2-flop synchronizer with a reset value of 1. It is reused for any other asynchronous pin.

Test Plan:
- CLKS_PER_BIT=16; send 0x1A5 with a good stop bit -> data=9'h1A5, done high for exactly 1 cycle at the computed cycle, framing_error=0.
- Drive a 5-cycle low glitch on idle rx -> no done; state returns to IDLE; framing_error stays 0; the next frame 0x0F3 is received correctly.
- Send 0x155 with the stop bit low, then hold rx low for 40 bit times -> framing_error=1, no done, data unchanged; after rx rises, frame 0x0AA gives done, data=0x0AA, framing_error=0.
- Send 0x001, 0x1FF, 0x100 back-to-back with no idle gap -> three done pulses in order with the matching data values.
- Pull reset low during data bit 4 of 0x13C, release, then send 0x07E -> outputs are 0 during reset; only one done follows, with data=0x07E.
- With UART_RX_MAJORITY_EN, inject a 1-cycle inverted glitch exactly at the midpoint of bit 2 of 0x0C4 -> data=0x0C4. Without the macro, the same stimulus gives data=0x0C0.
